snake_led_blink: RTL

SNAKE_LED_BLINK -- requirements
Module: snake_led_blink

---
 rtl/snake_led_blink.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/snake_led_blink.sv
// snake_led_blink: Avalon-MM LED output register with optional hardware blink.
//
// Register map (word address):
//   0 DATA       rw  [WIDTH-1:0]
//   1 BLINK_MASK rw  [WIDTH-1:0]      (blink build only)
//   2 PRESCALE   rw  [DIV_WIDTH-1:0]  (blink build only)
//   3 STATUS     ro  bit0 = phase     (blink build only)
//   4 OUTSET     wo  DATA <= DATA | wdata
//   5 OUTCLEAR   wo  DATA <= DATA & ~wdata
//   6 OUT        ro  current out_port
//   7 reserved
//
// Ports:
//   clk        sole clock, rising edge
//   reset_n    asynchronous active-low reset
//   address    word address
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   combinational read data, zero wait states
//   out_port   LED drive
//
// Build option: define SNAKE_LED_BLINK_EN to include BLINK_MASK, PRESCALE, the
// blink counter and phase. Without it, addresses 1..3 read 0, ignore writes and
// out_port follows DATA directly.

module snake_led_blink #(
  parameter int unsigned          WIDTH       = 10,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0,
  parameter int unsigned          DIV_WIDTH   = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             wr_en;
  logic [WIDTH-1:0] wdata_w;
  logic [WIDTH-1:0] data_q, data_d;

  assign wr_en   = chipselect & ~write_n;
  assign wdata_w = writedata[WIDTH-1:0];

  // Bits of writedata above the register widths are deliberately ignored.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  always_comb begin
    data_d = data_q;
    if (wr_en) begin
      unique case (address)
        3'd0:    data_d = wdata_w;
        3'd4:    data_d = data_q | wdata_w;
        3'd5:    data_d = data_q & ~wdata_w;
        default: data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

`ifdef SNAKE_LED_BLINK_EN
  logic [WIDTH-1:0]     mask_q, mask_d;
  logic [DIV_WIDTH-1:0] prescale_q, prescale_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 phase_q, phase_d;

  always_comb begin
    mask_d     = mask_q;
    prescale_d = prescale_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;

    if (wr_en && (address == 3'd1)) begin
      mask_d = wdata_w;
    end

    // A PRESCALE write restarts the blink cycle and wins over a terminal count
    // on the same edge; this also keeps the counter from ever exceeding PRESCALE.
    if (wr_en && (address == 3'd2)) begin
      prescale_d = writedata[DIV_WIDTH-1:0];
      cnt_d      = '0;
      phase_d    = 1'b0;
    end else if (prescale_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == prescale_q) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      prescale_q <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      prescale_q <= prescale_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
    end
  end

  // Masked bits are forced dark during phase 1.
  assign out_port = data_q & ~(mask_q & {WIDTH{phase_q}});

  always_comb begin
    readdata = '0;
    unique case (address)
      3'd0: readdata[WIDTH-1:0]     = data_q;
      3'd1: readdata[WIDTH-1:0]     = mask_q;
      3'd2: readdata[DIV_WIDTH-1:0] = prescale_q;
      3'd3: readdata[0]             = phase_q;
      3'd6: readdata[WIDTH-1:0]     = out_port;
      default: readdata = '0;
    endcase
  end
`else
  assign out_port = data_q;

  always_comb begin
    readdata = '0;
    unique case (address)
      3'd0: readdata[WIDTH-1:0] = data_q;
      3'd6: readdata[WIDTH-1:0] = out_port;
      default: readdata = '0;
    endcase
  end
`endif

endmodule
